// File: rtl/ahb_mem_ctrl_if.sv
// AHB-lite slave-side bus bundle for ahb_mem_ctrl.
// Address/data-phase requests from the master, response back from the slave.
interface ahb_mem_ctrl_if;
    logic        hsel;
    logic [1:0]  fifo_pad_htrans;
    logic [31:0] fifo_pad_haddr;
    logic [2:0]  fifo_pad_hsize;
    logic        fifo_pad_hwrite;
    logic [1:0]  fifo_pad_hburst;
    logic [3:0]  fifo_pad_hprot;
    logic [31:0] biu_pad_hwdata;
    logic        pad_biu_hready;
    logic [1:0]  pad_biu_hresp;
    logic [31:0] pad_biu_hrdata;

    modport master (
        output hsel, fifo_pad_htrans, fifo_pad_haddr,
        output fifo_pad_hsize, fifo_pad_hwrite,
        output fifo_pad_hburst, fifo_pad_hprot,
        output biu_pad_hwdata,
        input  pad_biu_hready, pad_biu_hresp, pad_biu_hrdata
    );

    modport slave (
        input  hsel, fifo_pad_htrans, fifo_pad_haddr,
        input  fifo_pad_hsize, fifo_pad_hwrite,
        input  fifo_pad_hburst, fifo_pad_hprot,
        input  biu_pad_hwdata,
        output pad_biu_hready, pad_biu_hresp, pad_biu_hrdata
    );
endinterface

// File: rtl/ahb_mem_ctrl.sv
// AHB-lite to single-port SRAM controller with programmable wait states.
// Define AHB_MEM_CTRL_ERR_EN to enable out-of-window ERROR responses.
module ahb_mem_ctrl #(
    parameter int          MEM_AW    = 15,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_b,
    ahb_mem_ctrl_if.slave     ahb,
    input  logic [3:0]        wait_num,
    output logic              mem_cen,
    output logic [3:0]        mem_wen,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [2:0] {
        IDLE, WAIT, RD_REQ, RD_DATA, WR, ERR1, ERR2
    } state_t;

    state_t            state, state_nxt, branch;
    logic [3:0]        cnt;
    logic [3:0]        lanes_q, lanes_nxt;
    logic [MEM_AW-1:0] addr_q;
    logic              wr_q;
    logic              hready;
    logic              accept;
    logic              err_hit;

`ifdef AHB_MEM_CTRL_ERR_EN
    assign err_hit = ahb.fifo_pad_haddr[31:MEM_AW+2]
                     != BASE_ADDR[31:MEM_AW+2];
`else
    assign err_hit = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, ahb.fifo_pad_hburst, ahb.fifo_pad_hprot,
                         ahb.fifo_pad_haddr[31:MEM_AW+2], BASE_ADDR[0]};

    // ERR2 shows hready=1 but must not start a new transfer
    assign accept = ahb.hsel && ahb.fifo_pad_htrans[1] && hready
                    && (state != ERR2);

    always_comb begin
        lanes_nxt = 4'hF;
        unique case (1'b1)
            (ahb.fifo_pad_hsize == 3'd0):
                lanes_nxt = 4'b0001 << ahb.fifo_pad_haddr[1:0];
            (ahb.fifo_pad_hsize == 3'd1):
                lanes_nxt = ahb.fifo_pad_haddr[1] ? 4'b1100 : 4'b0011;
            default:
                lanes_nxt = 4'hF;
        endcase
    end

    always_comb begin
        branch = RD_REQ;
        if (err_hit)
            branch = ERR1;
        else if (wait_num != 4'd0)
            branch = WAIT;
        else if (ahb.fifo_pad_hwrite)
            branch = WR;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RD_DATA, WR: state_nxt = accept ? branch : IDLE;
            WAIT: begin
                if (cnt == 4'd1)
                    state_nxt = wr_q ? WR : RD_REQ;
            end
            RD_REQ:  state_nxt = RD_DATA;
            ERR1:    state_nxt = ERR2;
            ERR2:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            lanes_q <= 4'd0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= ahb.fifo_pad_haddr[MEM_AW+1:2];
                lanes_q <= lanes_nxt;
                wr_q    <= ahb.fifo_pad_hwrite;
                cnt     <= wait_num;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        hready  = 1'b1;
        mem_cen = 1'b1;
        mem_wen = 4'hF;
        mem_din = 32'h0;
        ahb.pad_biu_hresp  = 2'd0;
        ahb.pad_biu_hrdata = 32'h0;
        case (state)
            WAIT:   hready = 1'b0;
            RD_REQ: begin
                hready  = 1'b0;
                mem_cen = 1'b0;
            end
            RD_DATA: ahb.pad_biu_hrdata = mem_dout;
            WR: begin
                mem_cen = 1'b0;
                mem_wen = ~lanes_q;
                mem_din = ahb.biu_pad_hwdata;
            end
            ERR1: begin
                hready = 1'b0;
                ahb.pad_biu_hresp = 2'd1;
            end
            ERR2: ahb.pad_biu_hresp = 2'd1;
            default: ;
        endcase
    end

    assign ahb.pad_biu_hready = hready;
    assign mem_addr           = addr_q;

endmodule
